mmio_uart_tx_bridge: RTL and testbench

//  Sits on the processor data-memory bus, between the processor's address_dmem/data/wren outputs and dmem.

---
 rtl/mmio_uart_tx_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_mmio_uart_tx_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_bridge.sv
// mmio_uart_tx_bridge
//  Sits between the processor data-memory port and dmem. A 4-word MMIO window
//  at MMIO_BASE feeds a byte FIFO drained by an 8N1 UART transmitter. All other
//  accesses pass through to dmem. Read data keeps dmem's one-cycle latency.
//  Optional feature macro: MMIO_UART_TX_IRQ_EN (adds irq_tx and CTRL bit2 irq_en).
module mmio_uart_tx_bridge #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [11:0] MMIO_BASE    = 12'hFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic [31:0] q_dmem,
  output logic        dmem_wren,
  output logic [31:0] q_proc,
  output logic        uart_tx,
  output logic        tx_busy
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        irq_tx
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Address decode and bus steering
  logic       hit;
  logic [1:0] offset;
  logic       wr_txdata;
  logic       wr_ctrl;
  logic       unused_data;

  assign hit         = (address_dmem[11:2] == MMIO_BASE[11:2]);
  assign offset      = address_dmem[1:0];
  assign dmem_wren   = wren & ~hit;
  assign wr_txdata   = wren & hit & (offset == 2'd0);
  assign wr_ctrl     = wren & hit & (offset == 2'd2);
  assign unused_data = ^data[31:8];

  // State
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tx_en_q, tx_en_d;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          hit_q;
  logic [31:0]   mmio_q, mmio_d;
  logic          irq_en_rd;

  logic empty, full, tx_active, baud_last, pop, push_ok, ovf_set;
  logic [8:0] count_ext;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign tx_active = (state_q != IDLE);
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign count_ext = 9'(count_q);
  // A full FIFO still accepts a push when the transmitter frees a slot that cycle
  assign push_ok   = wr_txdata & (~full | pop);
  assign ovf_set   = wr_txdata & full & ~pop;

  // Transmit FSM: next state, shift register and serial line
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, occupancy, overflow flag, control and MMIO read mux
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    ovf_d = ovf_q;
    if (wr_ctrl && data[1]) ovf_d = 1'b0;
    else if (ovf_set)       ovf_d = 1'b1;
    tx_en_d = wr_ctrl ? data[0] : tx_en_q;
    mmio_d  = 32'h0;
    case (offset)
      2'd1:    mmio_d = {20'b0, count_ext[7:0], ovf_q, tx_active, full, empty};
      2'd2:    mmio_d = {29'b0, irq_en_rd, 1'b0, tx_en_q};
      default: mmio_d = 32'h0;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= data[7:0];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_en_q  <= 1'b1;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h0;
      tx_q     <= 1'b1;
      hit_q    <= 1'b0;
      mmio_q   <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_en_q  <= tx_en_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      hit_q    <= hit;
      mmio_q   <= mmio_d;
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq_en_rd = irq_en_q;
  assign irq_tx    = irq_q;

  // Interrupt enable and registered "transmitter drained" interrupt
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= data[2];
      irq_q <= irq_en_q & empty & ~tx_active;
    end
  end
`else
  assign irq_en_rd = 1'b0;
`endif

  assign q_proc  = hit_q ? mmio_q : q_dmem;
  assign uart_tx = tx_q;
  assign tx_busy = ~empty | tx_active;

endmodule

// File: tb/tb_mmio_uart_tx_bridge.sv
// Testbench for mmio_uart_tx_bridge (CLKS_PER_BIT=4, FIFO_DEPTH=4, MMIO_BASE=12'hFF0).
// Bus vectors from a table, UART frames decoded by a line monitor and checked
// against a scoreboard of bytes expected to be transmitted.
module tb_mmio_uart_tx_bridge;
  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_GAP = 10 * CPB + 1;
  localparam int NV        = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        dmem_wren;
  logic [31:0] q_proc;
  logic        uart_tx;
  logic        tx_busy;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        irq_tx;
`endif

  mmio_uart_tx_bridge #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .MMIO_BASE(12'hFF0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .address_dmem(address_dmem),
    .data(data),
    .wren(wren),
    .q_dmem(q_dmem),
    .dmem_wren(dmem_wren),
    .q_proc(q_proc),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .irq_tx(irq_tx)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural dmem: one-cycle synchronous read
  logic [31:0] dmem [0:4095];
  always @(posedge clock) begin
    if (dmem_wren) dmem[address_dmem] <= data;
    q_dmem <= dmem[address_dmem];
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [NV];

  typedef struct {
    logic [9:0] bits;
    int         start;
  } rx_t;
  rx_t        rx_q [$];
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One bus cycle: present address/data, check write steering, then check read data
  task automatic xact(input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic exp_we, input logic chk, input logic [31:0] exp_rd,
                      input string tag);
    address_dmem = a;
    data         = d;
    wren         = w;
    #1;
    check({tag, "_dmem_wren"}, dmem_wren, exp_we);
    tick();
    wren         = 1'b0;
    address_dmem = 12'h000;
    if (chk) check({tag, "_q_proc"}, q_proc, exp_rd);
    $display("xact %s %s addr=%h wdata=%h q_proc=%h", tag, w ? "W" : "R", a, d, q_proc);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic accepted);
    xact(1'b1, 12'hFF0, {24'h0, b}, 1'b0, 1'b0, 32'h0, $sformatf("push_%h", b));
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic expect_frames(input int n, input logic chk_gap);
    int         prev_start;
    int         waited;
    rx_t        r;
    logic [7:0] e;
    prev_start = 0;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (rx_q.size() == 0 && waited < 400) begin
        tick();
        waited++;
      end
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got no frame after %0d cycles, expected frame %0d of %0d", waited, i, n);
        return;
      end
      r = rx_q.pop_front();
      check("start_bit", r.bits[0], 1'b0);
      check("stop_bit", r.bits[9], 1'b1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_extra: got byte %h, expected no frame", r.bits[8:1]);
      end else begin
        e = exp_q.pop_front();
        check("frame_byte", r.bits[8:1], e);
      end
      if (chk_gap && i > 0) check("frame_spacing", r.start - prev_start, FRAME_GAP);
      prev_start = r.start;
      $display("frame %0d byte=%h start_cycle=%0d", i, r.bits[8:1], r.start);
    end
  endtask

  // Line monitor: samples each bit mid-period, aborts on reset
  initial begin : monitor
    logic       m_busy;
    logic       m_prev;
    int         m_off;
    int         m_start;
    logic [9:0] m_bits;
    rx_t        m_rec;
    m_busy = 1'b0;
    m_prev = 1'b1;
    m_off = 0;
    m_start = 0;
    m_bits = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset !== 1'b1) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (m_prev && !uart_tx) begin
          m_busy  = 1'b1;
          m_off   = 0;
          m_start = cyc;
          m_bits  = '0;
        end
      end else begin
        m_off++;
        if (m_off % CPB == CPB / 2) m_bits[m_off / CPB] = uart_tx;
        if (m_off == 9 * CPB + CPB / 2) begin
          m_rec.bits  = m_bits;
          m_rec.start = m_start;
          rx_q.push_back(m_rec);
          m_busy = 1'b0;
        end
      end
      m_prev = (reset !== 1'b1) ? 1'b1 : uart_tx;
    end
  end

  initial begin : main
    logic [9:0] frame;
    logic       line_dropped;

    //          wr    addr     wdata         we    chk   expected read
    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h020, 32'h0BADF00D, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 12'h020, 32'h0,        1'b0, 1'b1, 32'h0BADF00D};
    vecs[4]  = '{1'b0, 12'hFF1, 32'h0,        1'b0, 1'b1, 32'h00000001};
    vecs[5]  = '{1'b0, 12'hFF2, 32'h0,        1'b0, 1'b1, 32'h00000001};
    vecs[6]  = '{1'b1, 12'hFF3, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 12'hFF3, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 12'hFEF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 12'hFEF, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 12'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 12'hFF2, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 12'hFF2, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 12'hFF2, 32'h1,        1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 12'hFF1, 32'h0,        1'b0, 1'b1, 32'h00000001};

    for (int i = 0; i < 4096; i++) dmem[i] = 32'h0;
    dmem[0] = 32'h12345678;

    reset = 1'b0;
    wren = 1'b0;
    address_dmem = 12'h000;
    data = 32'h0;

    // Reset state
    repeat (3) tick();
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_q_proc", q_proc, 32'h12345678);
`ifdef MMIO_UART_TX_IRQ_EN
    check("rst_irq_tx", irq_tx, 1'b0);
`endif
    reset = 1'b1;
    tick();

    // Table-driven bus vectors
    for (int i = 0; i < NV; i++) begin
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_we, vecs[i].chk,
           vecs[i].exp_rd, $sformatf("vec%0d", i));
    end
    check("dmem_ff3_untouched", dmem[12'hFF3], 32'h0);
    check("dmem_ff2_untouched", dmem[12'hFF2], 32'h0);

    // Single byte: exact line waveform
    push_byte(8'hA5, 1'b1);
    check("a5_busy", tx_busy, 1'b1);
    check("a5_line_idle", uart_tx, 1'b1);
    tick();
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      check($sformatf("a5_line_c%0d", i), uart_tx, frame[i / CPB]);
      tick();
    end
    check("a5_line_after", uart_tx, 1'b1);
    check("a5_busy_after", tx_busy, 1'b0);
    expect_frames(1, 1'b0);

    // Overflow with transmitter disabled
    xact(1'b1, 12'hFF2, 32'h0, 1'b0, 1'b0, 32'h0, "ctrl_off");
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    push_byte(8'h55, 1'b0);
    xact(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b1, 32'h0000004A, "ovf_status");
    xact(1'b0, 12'hFF2, 32'h0, 1'b0, 1'b1, 32'h0, "ovf_ctrl");
    xact(1'b1, 12'hFF2, 32'h3, 1'b0, 1'b0, 32'h0, "ctrl_clr");
    xact(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b1, 32'h00000042, "clr_status");
    expect_frames(4, 1'b1);

    // Full FIFO push in the same cycle as a pop
    xact(1'b1, 12'hFF2, 32'h0, 1'b0, 1'b0, 32'h0, "ctrl_off2");
    repeat (10) tick();
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    push_byte(8'h63, 1'b1);
    push_byte(8'h64, 1'b1);
    xact(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b1, 32'h00000042, "full_status");
    xact(1'b1, 12'hFF2, 32'h1, 1'b0, 1'b0, 32'h0, "ctrl_on");
    push_byte(8'h65, 1'b1);
    xact(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b1, 32'h00000046, "fullpop_status");
    expect_frames(5, 1'b1);

`ifdef MMIO_UART_TX_IRQ_EN
    // Interrupt raised one clock after STOP, dropped after a new push
    repeat (10) tick();
    push_byte(8'h3C, 1'b1);
    tick();
    check("irq_start", uart_tx, 1'b0);
    xact(1'b1, 12'hFF2, 32'h5, 1'b0, 1'b0, 32'h0, "ctrl_irq");
    repeat (10 * CPB - 1) tick();
    check("irq_low_at_idle", irq_tx, 1'b0);
    check("irq_line_idle", uart_tx, 1'b1);
    tick();
    check("irq_high", irq_tx, 1'b1);
    push_byte(8'hC3, 1'b1);
    check("irq_lag", irq_tx, 1'b1);
    tick();
    check("irq_dropped", irq_tx, 1'b0);
    expect_frames(2, 1'b0);
    xact(1'b0, 12'hFF2, 32'h0, 1'b0, 1'b1, 32'h00000005, "irq_ctrl");
`endif

    // Reset during DATA bit 3
    repeat (10) tick();
    xact(1'b1, 12'hFF0, 32'h66, 1'b0, 1'b0, 32'h0, "push_66");
    tick();
    check("mid_start", uart_tx, 1'b0);
    repeat (4 * CPB + 1) tick();
    check("mid_bit3", uart_tx, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_line", uart_tx, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    xact(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b1, 32'h00000001, "mid_status");
    xact(1'b0, 12'hFF2, 32'h0, 1'b0, 1'b1, 32'h00000001, "mid_ctrl");
    line_dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) line_dropped = 1'b1;
      tick();
    end
    check("mid_no_frames", line_dropped, 1'b0);
    check("stray_frames", rx_q.size(), 0);
    check("unsent_bytes", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected normal completion");
    $fatal(1, "watchdog");
  end

endmodule
